// File: rtl/multi_pattern_counter_pkg.sv
// Shared widths and helpers for the multi-channel serial pattern counter.
package multi_pattern_counter_pkg;

    localparam int DEF_PAT_W   = 8;
    localparam int DEF_NUM_PAT = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int MAX_PAT_W   = 32;

    // Sliced down to PAT_W by users; sized for the widest supported window.
    localparam logic [MAX_PAT_W-1:0] PAT_ZERO = '0;

    function automatic int idx_w(input int num_pat);
        return (num_pat <= 1) ? 1 : $clog2(num_pat);
    endfunction

endpackage

// File: rtl/multi_pattern_counter_if.sv
// Control/status bundle of the pattern counter. PAT_MASK_EN adds the pat_mask field.
interface multi_pattern_counter_if
    import multi_pattern_counter_pkg::*;
#(
    parameter int PAT_W   = DEF_PAT_W,
    parameter int NUM_PAT = DEF_NUM_PAT,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int IDX_W   = idx_w(NUM_PAT)
);
    logic                     enable;
    logic                     bit_in;
    logic                     bit_valid;
    logic                     overlap;
    logic                     pat_wr;
    logic [IDX_W-1:0]         pat_idx;
    logic [PAT_W-1:0]         pat_data;
`ifdef PAT_MASK_EN
    logic [PAT_W-1:0]         pat_mask;
`endif
    logic                     clr_counts;
    logic [NUM_PAT-1:0]       match_vec;
    logic [NUM_PAT*CNT_W-1:0] match_count;
    logic [NUM_PAT-1:0]       count_sat;
    logic                     ready;

    modport master (
        output enable, bit_in, bit_valid, overlap, pat_wr, pat_idx, pat_data,
`ifdef PAT_MASK_EN
        output pat_mask,
`endif
        output clr_counts,
        input  match_vec, match_count, count_sat, ready
    );

    modport slave (
        input  enable, bit_in, bit_valid, overlap, pat_wr, pat_idx, pat_data,
`ifdef PAT_MASK_EN
        input  pat_mask,
`endif
        input  clr_counts,
        output match_vec, match_count, count_sat, ready
    );

endinterface

// File: rtl/pattern_match_channel.sv
// One pattern channel: programmable pattern, non-overlap tracking and saturating hit counter.
// PAT_MASK_EN adds a per-channel don't-care mask captured with the pattern write.
module pattern_match_channel
    import multi_pattern_counter_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift,
    input  logic [PAT_W-1:0] win_next,
    input  logic             full_next,
    input  logic             overlap,
    input  logic             wr,
    input  logic [PAT_W-1:0] wr_pat,
`ifdef PAT_MASK_EN
    input  logic [PAT_W-1:0] wr_mask,
`endif
    input  logic             clr,
    output logic             match_p1,
    output logic [CNT_W-1:0] count,
    output logic             sat
);
    localparam int               SINCE_W   = $clog2(PAT_W + 1);
    localparam logic [SINCE_W-1:0] SINCE_MAX = SINCE_W'(PAT_W);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    logic [PAT_W-1:0]   pat;
    logic [PAT_W-1:0]   mask;
    logic               chan_valid;
    logic [SINCE_W-1:0] since;
    logic [SINCE_W-1:0] since_next;
    logic               hit_p0;

    function automatic logic [SINCE_W-1:0] since_inc(input logic [SINCE_W-1:0] s);
        return (s >= SINCE_MAX) ? SINCE_MAX : s + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? CNT_MAX : c + 1'b1;
    endfunction

`ifdef PAT_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  mask <= PAT_ZERO[PAT_W-1:0];
        else if (wr) mask <= wr_mask;
    end
`else
    assign mask = PAT_ZERO[PAT_W-1:0];
`endif

    // Stage p0: compare against the window that includes this cycle's bit
    assign since_next = shift ? since_inc(since) : since;
    assign hit_p0 = shift & chan_valid & full_next
                  & (((win_next ^ pat) & ~mask) == PAT_ZERO[PAT_W-1:0])
                  & (overlap | (since_next >= SINCE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat        <= PAT_ZERO[PAT_W-1:0];
            chan_valid <= 1'b0;
            since      <= '0;
        end else begin
            if (wr) begin
                pat        <= wr_pat;
                chan_valid <= 1'b1;
            end
            if (wr || hit_p0) since <= '0;
            else              since <= since_next;
        end
    end

    // Stage p1: registered pulse and counter update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_p1 <= 1'b0;
            count    <= '0;
            sat      <= 1'b0;
        end else begin
            match_p1 <= hit_p0;
            if (clr) begin
                count <= '0;
                sat   <= 1'b0;
            end else if (hit_p0) begin
                count <= cnt_sat_inc(count);
                if (count == CNT_MAX) sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_pattern_counter.sv
// Serial window shifter feeding NUM_PAT pattern channels; owns window, fill, write decode, ready.
// PAT_MASK_EN routes the per-channel don't-care mask from the bus into each channel.
module multi_pattern_counter
    import multi_pattern_counter_pkg::*;
#(
    parameter int PAT_W   = DEF_PAT_W,
    parameter int NUM_PAT = DEF_NUM_PAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input logic                    clk,
    input logic                    rst_n,
    multi_pattern_counter_if.slave bus
);
    localparam int                IDX_W    = idx_w(NUM_PAT);
    localparam int                FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic                     shift_p0;
    logic [PAT_W-1:0]         win;
    logic [PAT_W-1:0]         win_next;
    logic [FILL_W-1:0]        fill;
    logic [FILL_W-1:0]        fill_next;
    logic                     full_next;
    logic                     ready_q;
    logic [NUM_PAT-1:0]       match_w;
    logic [NUM_PAT-1:0]       sat_w;
    logic [NUM_PAT*CNT_W-1:0] count_w;

    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
        return (f >= FILL_MAX) ? FILL_MAX : f + 1'b1;
    endfunction

    // Stage p0: shift strobe and next window shared by every channel
    assign shift_p0  = bus.enable & bus.bit_valid;
    assign win_next  = shift_p0 ? {win[PAT_W-2:0], bus.bit_in} : win;
    assign fill_next = shift_p0 ? fill_inc(fill) : fill;
    assign full_next = (fill_next == FILL_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win     <= PAT_ZERO[PAT_W-1:0];
            fill    <= '0;
            ready_q <= 1'b0;
        end else begin
            win     <= win_next;
            fill    <= fill_next;
            ready_q <= bus.enable;
        end
    end

    for (genvar i = 0; i < NUM_PAT; i++) begin : g_ch
        pattern_match_channel #(
            .PAT_W (PAT_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .shift     (shift_p0),
            .win_next  (win_next),
            .full_next (full_next),
            .overlap   (bus.overlap),
            .wr        (bus.pat_wr && (bus.pat_idx == IDX_W'(i))),
            .wr_pat    (bus.pat_data),
`ifdef PAT_MASK_EN
            .wr_mask   (bus.pat_mask),
`endif
            .clr       (bus.clr_counts),
            .match_p1  (match_w[i]),
            .count     (count_w[i*CNT_W +: CNT_W]),
            .sat       (sat_w[i])
        );
    end

    assign bus.match_vec   = match_w;
    assign bus.match_count = count_w;
    assign bus.count_sat   = sat_w;
    assign bus.ready       = ready_q;

endmodule
